// File: rtl/p2a_push_fsm_pkg.sv
// Shared types and constants for the P2A completion push sequencer.
// Completion kinds, AXI response codes and the sequencer state encoding live here.
package p2a_push_fsm_pkg;

  typedef enum logic [2:0] {
    CPL_NONE   = 3'd0,
    CPL_WR_OK  = 3'd1,
    CPL_WR_ERR = 3'd2,
    CPL_RD_OK  = 3'd3,
    CPL_RD_ERR = 3'd4
  } cpl_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    R_PUSH = 2'd1,
    R_WAIT = 2'd2
  } p2a_push_state_t;

  // A zero length field means the maximum completion of 1024 DW.
  function automatic logic [10:0] decodeLength(input logic [9:0] len);
    return (len == 10'd0) ? 11'd1024 : {1'b0, len};
  endfunction

endpackage

// File: rtl/p2a_push_fsm_beat_slicer.sv
// Holds the current data chunk, the beat index and the remaining DW count.
// It presents one AXI beat at a time and flags the last beat of the burst.
module p2a_beat_slicer
  import p2a_push_fsm_pkg::*;
#(
  parameter int DATA_WIDTH     = 1024,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      load_hdr_i,
  input  logic                      reload_i,
  input  logic                      push_i,
  input  logic [9:0]                length_i,
  input  logic [1:0]                resp_i,
  input  logic [DATA_WIDTH-1:0]     data_i,
  output logic [AXI_DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]                r_resp_o,
  output logic                      last_beat_o,
  output logic                      chunk_end_o
);

  localparam int BEATS = DATA_WIDTH / AXI_DATA_WIDTH;
  localparam int DPB   = AXI_DATA_WIDTH / 32;
  localparam int IW    = $clog2(BEATS);

  logic [BEATS-1:0][AXI_DATA_WIDTH-1:0] chunk_q, chunk_d;
  logic [IW-1:0]                        beat_idx_q, beat_idx_d;
  logic [10:0]                          rem_dw_q, rem_dw_d;
  logic [1:0]                           resp_q, resp_d;

  // A reload in the same cycle as a push still consumes the outgoing beat.
  always_comb begin
    chunk_d    = chunk_q;
    beat_idx_d = beat_idx_q;
    rem_dw_d   = rem_dw_q;
    resp_d     = resp_q;
    if (load_hdr_i) begin
      chunk_d    = data_i;
      beat_idx_d = '0;
      rem_dw_d   = decodeLength(length_i);
      resp_d     = resp_i;
    end else begin
      if (push_i) begin
        rem_dw_d   = rem_dw_q - ((rem_dw_q < 11'(DPB)) ? rem_dw_q : 11'(DPB));
        beat_idx_d = beat_idx_q + 1'b1;
      end
      if (reload_i) begin
        chunk_d    = data_i;
        beat_idx_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chunk_q    <= '0;
      beat_idx_q <= '0;
      rem_dw_q   <= '0;
      resp_q     <= RESP_OKAY;
    end else begin
      chunk_q    <= chunk_d;
      beat_idx_q <= beat_idx_d;
      rem_dw_q   <= rem_dw_d;
      resp_q     <= resp_d;
    end
  end

  assign r_data_o    = chunk_q[beat_idx_q];
  assign r_resp_o    = resp_q;
  assign last_beat_o = (rem_dw_q <= 11'(DPB));
  assign chunk_end_o = (beat_idx_q == IW'(BEATS - 1));

endmodule

// File: rtl/p2a_push_fsm.sv
// Sequencer pushing one P2A completion into the AXI B or R response FIFO.
// Long reads pull further data chunks from P2A through the grant/command handshake.
module p2a_push_fsm
  import p2a_push_fsm_pkg::*;
#(
  parameter int DATA_WIDTH     = 1024,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  cpl_t                      Cpl_Type,
  input  logic [9:0]                Cpl_Length,
  input  logic [DATA_WIDTH-1:0]     Cpl_Data,
  output logic                      Cpl_Grant,
  output logic                      Cpl_Command,
  input  logic                      b_full,
  output logic                      b_push,
  output logic [1:0]                b_resp,
  input  logic                      r_full,
  output logic                      r_push,
  output logic [AXI_DATA_WIDTH-1:0] r_data,
  output logic [1:0]                r_resp,
  output logic                      r_last
);

  p2a_push_state_t state_q, state_d;
  logic            loadHdr, reloadChunk, lastBeat, chunkEnd;
  logic [1:0]      hdrResp;

  p2a_beat_slicer #(
    .DATA_WIDTH    (DATA_WIDTH),
    .AXI_DATA_WIDTH(AXI_DATA_WIDTH)
  ) u_slicer (
    .clk_i      (ACLK),
    .rst_ni     (ARESETn),
    .load_hdr_i (loadHdr),
    .reload_i   (reloadChunk),
    .push_i     (r_push),
    .length_i   (Cpl_Length),
    .resp_i     (hdrResp),
    .data_i     (Cpl_Data),
    .r_data_o   (r_data),
    .r_resp_o   (r_resp),
    .last_beat_o(lastBeat),
    .chunk_end_o(chunkEnd)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  assign Cpl_Command = (state_q != IDLE);

  // Strobes are masked while reset is held so nothing is granted or pushed.
  always_comb begin
    state_d     = state_q;
    Cpl_Grant   = 1'b0;
    b_push      = 1'b0;
    b_resp      = RESP_OKAY;
    r_push      = 1'b0;
    r_last      = 1'b0;
    loadHdr     = 1'b0;
    reloadChunk = 1'b0;
    hdrResp     = (Cpl_Type == CPL_RD_ERR) ? RESP_SLVERR : RESP_OKAY;
    if (ARESETn) begin
      case (state_q)
        IDLE: begin
          case (Cpl_Type)
            CPL_WR_OK, CPL_WR_ERR: begin
              if (!b_full) begin
                b_push    = 1'b1;
                Cpl_Grant = 1'b1;
                b_resp    = (Cpl_Type == CPL_WR_ERR) ? RESP_SLVERR : RESP_OKAY;
              end
            end
            CPL_RD_OK, CPL_RD_ERR: begin
              Cpl_Grant = 1'b1;
              loadHdr   = 1'b1;
              state_d   = R_PUSH;
            end
            default: ;
          endcase
        end
        R_PUSH: begin
          r_last = lastBeat;
          if (!r_full) begin
            r_push = 1'b1;
            if (lastBeat) begin
              state_d = IDLE;
            end else if (chunkEnd) begin
              if (Cpl_Type != CPL_NONE) begin
                Cpl_Grant   = 1'b1;
                reloadChunk = 1'b1;
              end else begin
                state_d = R_WAIT;
              end
            end
          end
        end
        R_WAIT: begin
          if (Cpl_Type != CPL_NONE) begin
            Cpl_Grant   = 1'b1;
            reloadChunk = 1'b1;
            state_d     = R_PUSH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
